traffic_intersection_ctrl: RTL and testbench
============================================

// Module: traffic_intersection_ctrl
// PURPOSE
//  Two-road (NS/EW) intersection controller, successor to the single-lamp RED/GREEN/YELLOW sequencer.
//  Phase durations are parametrised; adds all-red clearance, a latched pedestrian-walk phase and a
//  night flashing-yellow mode. Sits at top of the traffic subsystem; lamp outputs drive the pad/LED drivers.
// PARAMETERS
//  GREEN_CYC   5  cycles a direction holds green (>=1)
//  YELLOW_CYC  2  cycles of yellow after green (>=1)
//  ALLRED_CYC  1  cycles of all-red clearance between directions (>=1)
//  WALK_CYC    4  cycles of pedestrian walk (all roads red, walk=1) (>=1)
//  FLASH_CYC   2  half-period of flashing yellow in flash mode (>=1)
//  CNT_W       4  phase-timer width; must satisfy 2**CNT_W > max(all *_CYC)-1 (elaboration check)
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous, active-high reset
//  ped_req    in   1  pedestrian button, level or pulse; sampled every cycle
//  flash_en   in   1  night mode request, level
//  ns_red     out  1  NS red lamp
//  ns_yellow  out  1  NS yellow lamp
//  ns_green   out  1  NS green lamp
//  ew_red     out  1  EW red lamp
//  ew_yellow  out  1  EW yellow lamp
//  ew_green   out  1  EW green lamp
//  walk       out  1  pedestrian walk lamp
//  ped_pend   out  1  pedestrian request latched, not yet served
// BEHAVIOUR
//  - States: NS_G, NS_Y, AR_EW (all-red, next EW), EW_G, EW_Y, AR_NS (all-red, next NS), WALK, FLASH_ON, FLASH_OFF.
//  - Moore outputs decoded from state register only; lamps change in the cycle after the state edge.
//    Exactly one lamp per road is lit except FLASH_OFF (all lamps off). walk=1 only in WALK.
//  - Phase timer: loaded with DUR-1 on state entry, decrements; transition occurs on the edge where timer==0.
//    Each state therefore lasts exactly its *_CYC cycles.
//  - Normal cycle: NS_G->NS_Y->AR_EW->EW_G->EW_Y->AR_NS->NS_G.
//  - ped_req: sets ped_pend on any cycle it is high (outside WALK). At the end of AR_EW or AR_NS with
//    ped_pend=1, go to WALK instead of next green; ped_pend clears on WALK entry. After WALK, go to the
//    green that AR_* would have chosen. A ped_req during WALK is ignored (not re-latched).
//  - flash_en=1 sampled in x_G: abort green, enter x_Y with full YELLOW_CYC (early terminate).
//    In x_Y/AR_*/WALK: finish the current phase; at end of any AR_* or WALK, enter FLASH_ON.
//  - FLASH_ON: both yellows lit, reds/greens off; FLASH_ON<->FLASH_OFF every FLASH_CYC cycles.
//    flash_en=0 sampled in FLASH_ON/OFF -> AR_NS (full ALLRED_CYC) then NS_G. ped_pend held, not served in flash.
//  - Simultaneous flash_en and pending ped at end of AR_*/WALK: flash wins; ped_pend stays set.
//  - Reset (any time, asynchronous): state=AR_NS, timer=ALLRED_CYC-1, ped_pend=0; outputs ns_red=ew_red=1,
//    all others 0. After release, first NS_G begins after ALLRED_CYC cycles.
//  - Safety invariant: never ns_green|ns_yellow concurrently with ew_green|ew_yellow except in FLASH_ON.
//  - Unreachable state encodings return to AR_NS on the next edge.
// STRUCTURE
//  - Package traffic_pkg: state enum typedef (tl_state_e), lamp-triple struct (r,y,g), default durations.
//  - One sub-module: tl_phase_timer (load, load_val[CNT_W-1:0], dec, zero flag) -- reusable down counter.
//  - Top: state register + next-state logic + ped latch + output decode.
// TESTING
//  - Reset release, no inputs -> 1 cyc all-red, 5 NS_G, 2 NS_Y, 1 AR, 5 EW_G, 2 EW_Y, 1 AR, repeat (period 16).
//  - 1-cycle ped_req pulse in NS_G -> ped_pend=1 until AR_EW ends, then walk=1 for 4 cycles, all red, then EW_G.
//  - flash_en=1 at 2nd NS_G cycle -> NS_Y next, 2 cyc, AR 1 cyc, then both yellows toggle on/off every 2 cycles.
//  - flash_en dropped in FLASH_OFF -> 1 cyc all red (ns_red=ew_red=1), then ns_green=1.
//  - ped_req + flash_en together in EW_G -> EW_Y, AR, FLASH (no WALK), ped_pend stays 1 through flash.
//  - rst pulse mid-WALK -> immediately walk=0, ns_red=ew_red=1, ped_pend=0; normal sequence resumes.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and default phase durations for the intersection controller.
//   tl_state_e : controller phase encoding
//   lamp_t     : one road's red/yellow/green lamp triple
package traffic_pkg;

   localparam int unsigned DEF_GREEN_CYC  = 5;
   localparam int unsigned DEF_YELLOW_CYC = 2;
   localparam int unsigned DEF_ALLRED_CYC = 1;
   localparam int unsigned DEF_WALK_CYC   = 4;
   localparam int unsigned DEF_FLASH_CYC  = 2;
   localparam int unsigned DEF_CNT_W      = 4;

   typedef enum logic [3:0] {
      ST_NS_G      = 4'd0,
      ST_NS_Y      = 4'd1,
      ST_AR_EW     = 4'd2,
      ST_EW_G      = 4'd3,
      ST_EW_Y      = 4'd4,
      ST_AR_NS     = 4'd5,
      ST_WALK      = 4'd6,
      ST_FLASH_ON  = 4'd7,
      ST_FLASH_OFF = 4'd8
   } tl_state_e;

   typedef struct packed {
      logic r;
      logic y;
      logic g;
   } lamp_t;

   localparam lamp_t LAMP_OFF    = '{r: 1'b0, y: 1'b0, g: 1'b0};
   localparam lamp_t LAMP_RED    = '{r: 1'b1, y: 1'b0, g: 1'b0};
   localparam lamp_t LAMP_YELLOW = '{r: 1'b0, y: 1'b1, g: 1'b0};
   localparam lamp_t LAMP_GREEN  = '{r: 1'b0, y: 1'b0, g: 1'b1};

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// Controller-facing signal bundle: pedestrian/night-mode requests in,
// lamp drives and pending-request status out.
//   master : controller side (requests in, lamps out)
//   slave  : environment side (requests out, lamps in)
interface traffic_intersection_ctrl_if;
   logic ped_req;
   logic flash_en;
   logic ns_red;
   logic ns_yellow;
   logic ns_green;
   logic ew_red;
   logic ew_yellow;
   logic ew_green;
   logic walk;
   logic ped_pend;

   modport master (
      input  ped_req, flash_en,
      output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pend
   );

   modport slave (
      output ped_req, flash_en,
      input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pend
   );
endinterface

// File: rtl/tl_phase_timer.sv
// Reusable loadable down counter used as the phase timer.
//   clk, rst  : clock, async active-high reset (counter -> RST_VAL)
//   load      : load load_val (has priority over dec)
//   load_val  : value loaded
//   dec       : decrement, saturating at zero
//   zero_c    : counter currently zero (combinational)
module tl_phase_timer #(
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    cnt_q <= CNT_W'(RST_VAL);
      else if (load)              cnt_q <= load_val;
      else if (dec && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with all-red clearance, latched
// pedestrian walk phase and night flashing-yellow mode.
//   clk, rst : clock, async active-high reset
//   bus      : ped_req/flash_en in; ns_*/ew_* lamps, walk, ped_pend out
// Lamp outputs are registered from the next state so they track the
// state register exactly.
module traffic_intersection_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_CYC  = DEF_GREEN_CYC,
   parameter int unsigned YELLOW_CYC = DEF_YELLOW_CYC,
   parameter int unsigned ALLRED_CYC = DEF_ALLRED_CYC,
   parameter int unsigned WALK_CYC   = DEF_WALK_CYC,
   parameter int unsigned FLASH_CYC  = DEF_FLASH_CYC,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   traffic_intersection_ctrl_if.master bus
);

   localparam int unsigned MAX_GY  = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
   localparam int unsigned MAX_AW  = (ALLRED_CYC > WALK_CYC) ? ALLRED_CYC : WALK_CYC;
   localparam int unsigned MAX_GYF = (MAX_GY > FLASH_CYC) ? MAX_GY : FLASH_CYC;
   localparam int unsigned MAX_CYC = (MAX_GYF > MAX_AW) ? MAX_GYF : MAX_AW;

   // Elaboration-time parameter sanity
   if ((2 ** CNT_W) <= (MAX_CYC - 1)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for longest phase");
   end
   if (GREEN_CYC < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1 || WALK_CYC < 1 || FLASH_CYC < 1) begin : g_bad_dur
      $error("all phase durations must be >= 1");
   end

   tl_state_e        state_q, state_nxt;
   logic             ped_pend_q, ped_pend_nxt;
   logic             walk_ew_q, walk_ew_nxt;   // green to resume after WALK: 1=EW, 0=NS
   logic             tmr_load, tmr_dec, tmr_zero_c;
   logic [CNT_W-1:0] tmr_val;
   lamp_t            ns_q, ew_q, ns_c, ew_c;
   logic             walk_q, walk_c;

   function automatic logic [CNT_W-1:0] phase_len(input tl_state_e s);
      case (s)
         ST_NS_G, ST_EW_G:          phase_len = CNT_W'(GREEN_CYC - 1);
         ST_NS_Y, ST_EW_Y:          phase_len = CNT_W'(YELLOW_CYC - 1);
         ST_WALK:                   phase_len = CNT_W'(WALK_CYC - 1);
         ST_FLASH_ON, ST_FLASH_OFF: phase_len = CNT_W'(FLASH_CYC - 1);
         default:                   phase_len = CNT_W'(ALLRED_CYC - 1);
      endcase
   endfunction

   tl_phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (ALLRED_CYC - 1)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero_c   (tmr_zero_c)
   );

   // State, pedestrian latch and registered lamp drives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_AR_NS;
         ped_pend_q <= 1'b0;
         walk_ew_q  <= 1'b0;
         ns_q       <= LAMP_RED;
         ew_q       <= LAMP_RED;
         walk_q     <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         ped_pend_q <= ped_pend_nxt;
         walk_ew_q  <= walk_ew_nxt;
         ns_q       <= ns_c;
         ew_q       <= ew_c;
         walk_q     <= walk_c;
      end
   end

   // Next-state, timer control and pedestrian latch
   always_comb begin
      state_nxt    = state_q;
      walk_ew_nxt  = walk_ew_q;
      ped_pend_nxt = ped_pend_q;
      tmr_load     = 1'b0;
      tmr_val      = '0;

      if (bus.ped_req && state_q != ST_WALK) ped_pend_nxt = 1'b1;

      case (state_q)
         ST_NS_G:  if (bus.flash_en || tmr_zero_c) state_nxt = ST_NS_Y;
         ST_NS_Y:  if (tmr_zero_c) state_nxt = ST_AR_EW;
         ST_EW_G:  if (bus.flash_en || tmr_zero_c) state_nxt = ST_EW_Y;
         ST_EW_Y:  if (tmr_zero_c) state_nxt = ST_AR_NS;
         ST_AR_EW, ST_AR_NS: begin
            if (tmr_zero_c) begin
               if (bus.flash_en) begin
                  state_nxt = ST_FLASH_ON;
               end else if (ped_pend_q) begin
                  state_nxt   = ST_WALK;
                  walk_ew_nxt = (state_q == ST_AR_EW);
               end else begin
                  state_nxt = (state_q == ST_AR_EW) ? ST_EW_G : ST_NS_G;
               end
            end
         end
         ST_WALK: begin
            if (tmr_zero_c) begin
               if (bus.flash_en)   state_nxt = ST_FLASH_ON;
               else if (walk_ew_q) state_nxt = ST_EW_G;
               else                state_nxt = ST_NS_G;
            end
         end
         ST_FLASH_ON: begin
            if (!bus.flash_en)   state_nxt = ST_AR_NS;
            else if (tmr_zero_c) state_nxt = ST_FLASH_OFF;
         end
         ST_FLASH_OFF: begin
            if (!bus.flash_en)   state_nxt = ST_AR_NS;
            else if (tmr_zero_c) state_nxt = ST_FLASH_ON;
         end
         default: state_nxt = ST_AR_NS;
      endcase

      // Every transition enters a different state, so entry == change
      if (state_nxt != state_q) begin
         tmr_load = 1'b1;
         tmr_val  = phase_len(state_nxt);
         if (state_nxt == ST_WALK) ped_pend_nxt = 1'b0;
      end
      tmr_dec = !tmr_load;
   end

   // Lamp decode of the upcoming state
   always_comb begin
      ns_c   = LAMP_RED;
      ew_c   = LAMP_RED;
      walk_c = 1'b0;
      case (state_nxt)
         ST_NS_G:      ns_c = LAMP_GREEN;
         ST_NS_Y:      ns_c = LAMP_YELLOW;
         ST_EW_G:      ew_c = LAMP_GREEN;
         ST_EW_Y:      ew_c = LAMP_YELLOW;
         ST_WALK:      walk_c = 1'b1;
         ST_FLASH_ON:  begin ns_c = LAMP_YELLOW; ew_c = LAMP_YELLOW; end
         ST_FLASH_OFF: begin ns_c = LAMP_OFF;    ew_c = LAMP_OFF;    end
         default:      ;
      endcase
   end

   assign bus.ns_red    = ns_q.r;
   assign bus.ns_yellow = ns_q.y;
   assign bus.ns_green  = ns_q.g;
   assign bus.ew_red    = ew_q.r;
   assign bus.ew_yellow = ew_q.y;
   assign bus.ew_green  = ew_q.g;
   assign bus.walk      = walk_q;
   assign bus.ped_pend  = ped_pend_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl. Observed vector is
// {ns_r,ns_y,ns_g, ew_r,ew_y,ew_g, walk, ped_pend}, sampled at negedge.
module tb_traffic_intersection_ctrl;

   localparam logic [5:0] NSG  = 6'b001_100;
   localparam logic [5:0] NSY  = 6'b010_100;
   localparam logic [5:0] AR   = 6'b100_100;
   localparam logic [5:0] EWG  = 6'b100_001;
   localparam logic [5:0] EWY  = 6'b100_010;
   localparam logic [5:0] FON  = 6'b010_010;
   localparam logic [5:0] FOFF = 6'b000_000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   traffic_intersection_ctrl_if tif ();

   traffic_intersection_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (tif)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] obs();
      return {tif.ns_red, tif.ns_yellow, tif.ns_green,
              tif.ew_red, tif.ew_yellow, tif.ew_green, tif.walk, tif.ped_pend};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // Check n consecutive cycles against one expected value, advancing a cycle each
   task automatic run(input string tag, input logic [5:0] lamps, input logic wk,
                      input logic pend, input int n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s[%0d]", tag, i), obs(), {lamps, wk, pend});
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      tif.ped_req  = 1'b0;
      tif.flash_en = 1'b0;
      @(negedge clk);
      check(tag, obs(), {AR, 1'b0, 1'b0});
      rst = 1'b0;
   endtask

   initial begin
      tif.ped_req  = 1'b0;
      tif.flash_en = 1'b0;
      @(negedge clk);

      // Normal cycle, period 16
      do_reset("rst1");
      run("n_ar0", AR, 0, 0, 1);
      run("n_nsg", NSG, 0, 0, 5);
      run("n_nsy", NSY, 0, 0, 2);
      run("n_arew", AR, 0, 0, 1);
      run("n_ewg", EWG, 0, 0, 5);
      run("n_ewy", EWY, 0, 0, 2);
      run("n_arns", AR, 0, 0, 1);
      run("n_nsg2", NSG, 0, 0, 1);

      // Pedestrian pulse in NS_G, walk after AR_EW, re-request in WALK ignored
      do_reset("rst2");
      run("p_ar0", AR, 0, 0, 1);
      tif.ped_req = 1'b1;
      run("p_nsg0", NSG, 0, 0, 1);
      tif.ped_req = 1'b0;
      run("p_nsg", NSG, 0, 1, 4);
      run("p_nsy", NSY, 0, 1, 2);
      run("p_arew", AR, 0, 1, 1);
      run("p_walk0", AR, 1, 0, 1);
      tif.ped_req = 1'b1;
      run("p_walk1", AR, 1, 0, 1);
      tif.ped_req = 1'b0;
      run("p_walk2", AR, 1, 0, 2);
      run("p_ewg", EWG, 0, 0, 5);
      run("p_ewy", EWY, 0, 0, 1);

      // Flash request at second NS_G cycle, exit from FLASH_OFF
      do_reset("rst3");
      run("f_ar0", AR, 0, 0, 1);
      run("f_nsg0", NSG, 0, 0, 1);
      tif.flash_en = 1'b1;
      run("f_nsg1", NSG, 0, 0, 1);
      run("f_nsy", NSY, 0, 0, 2);
      run("f_ar", AR, 0, 0, 1);
      run("f_on0", FON, 0, 0, 2);
      run("f_off0", FOFF, 0, 0, 2);
      run("f_on1", FON, 0, 0, 2);
      tif.flash_en = 1'b0;
      run("f_off1", FOFF, 0, 0, 1);
      run("f_exit_ar", AR, 0, 0, 1);
      run("f_nsg", NSG, 0, 0, 5);
      run("f_nsy", NSY, 0, 0, 1);

      // Ped + flash together in EW_G: flash wins, pend held, served after flash
      do_reset("rst4");
      run("pf_ar0", AR, 0, 0, 1);
      run("pf_nsg", NSG, 0, 0, 5);
      run("pf_nsy", NSY, 0, 0, 2);
      run("pf_arew", AR, 0, 0, 1);
      tif.ped_req  = 1'b1;
      tif.flash_en = 1'b1;
      run("pf_ewg", EWG, 0, 0, 1);
      tif.ped_req = 1'b0;
      run("pf_ewy", EWY, 0, 1, 2);
      run("pf_arns", AR, 0, 1, 1);
      run("pf_on0", FON, 0, 1, 2);
      run("pf_off0", FOFF, 0, 1, 2);
      run("pf_on1a", FON, 0, 1, 1);
      tif.flash_en = 1'b0;
      run("pf_on1b", FON, 0, 1, 1);
      run("pf_exit_ar", AR, 0, 1, 1);
      run("pf_walk", AR, 1, 0, 4);
      run("pf_nsg", NSG, 0, 0, 1);

      // Asynchronous reset in the middle of WALK
      do_reset("rst5");
      run("r_ar0", AR, 0, 0, 1);
      tif.ped_req = 1'b1;
      run("r_nsg0", NSG, 0, 0, 1);
      tif.ped_req = 1'b0;
      run("r_nsg", NSG, 0, 1, 4);
      run("r_nsy", NSY, 0, 1, 2);
      run("r_arew", AR, 0, 1, 1);
      run("r_walk", AR, 1, 0, 2);
      rst = 1'b1;
      #1;
      check("r_async", obs(), {AR, 1'b0, 1'b0});
      @(negedge clk);
      rst = 1'b0;
      run("r_ar1", AR, 0, 0, 1);
      run("r_nsg2", NSG, 0, 0, 5);
      run("r_nsy2", NSY, 0, 0, 2);
      run("r_arew2", AR, 0, 0, 1);
      run("r_ewg2", EWG, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
